// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencing controller for the five-stage core
// (fetch, decode, reg, alu, wb).
//
// Ports:
//   clk                - core clock; all state changes on the rising edge
//   arstn              - asynchronous active-low reset
//   reg_conflict_i     - decode depends on the reg-stage destination
//   branch_conflict_i  - a branch sits in reg, alu or wb
//   fetch_valid_i      - fetch presents an instruction this cycle
//   flush_i            - kill every in-flight instruction
//   pc_en_o            - PC/fetch register may advance (combinational)
//   decode_en_o        - decode pipeline register may load (combinational)
//   decode/reg/alu/wb_valid_o - registered stage-valid bits
//   state_o            - registered stall state: 0 RUN, 1 DEP, 2 BR
//   stall_cnt_o        - saturating count of stalled cycles since reset
//   stall_timeout_o    - sticky: one stall run lasted MAX_STALL cycles
module pipe_ctrl #(
  parameter int STALL_CNT_W = 16,
  parameter int MAX_STALL   = 8
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   reg_conflict_i,
  input  logic                   branch_conflict_i,
  input  logic                   fetch_valid_i,
  input  logic                   flush_i,
  output logic                   pc_en_o,
  output logic                   decode_en_o,
  output logic                   decode_valid_o,
  output logic                   reg_valid_o,
  output logic                   alu_valid_o,
  output logic                   wb_valid_o,
  output logic [1:0]             state_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   stall_timeout_o
);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_DEP = 2'd1,
    ST_BR  = 2'd2
  } state_e;

  localparam logic [7:0]             MAX_STALL_L = 8'(MAX_STALL);
  localparam logic [STALL_CNT_W-1:0] CNT_MAX     = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] CNT_ONE     = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic                   decode_valid_q, decode_valid_d;
  logic                   reg_valid_q, reg_valid_d;
  logic                   alu_valid_q, alu_valid_d;
  logic                   wb_valid_q, wb_valid_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]             run_len_q, run_len_d;
  logic                   timeout_q, timeout_d;
  logic                   stall_s;

  // Fetch freezes on any conflict or flush; decode reloads unless a
  // dependence holds it, but a flush always lets it load (the bubble).
  assign pc_en_o     = !reg_conflict_i && !branch_conflict_i && !flush_i;
  assign decode_en_o = !reg_conflict_i || flush_i;

  // Next-state decision: flush > dependence > branch > run.
  always_comb begin
    state_d        = ST_RUN;
    decode_valid_d = decode_valid_q;
    reg_valid_d    = reg_valid_q;
    alu_valid_d    = alu_valid_q;
    wb_valid_d     = wb_valid_q;
    if (flush_i) begin
      state_d        = ST_RUN;
      decode_valid_d = 1'b0;
      reg_valid_d    = 1'b0;
      alu_valid_d    = 1'b0;
      wb_valid_d     = 1'b0;
    end else if (reg_conflict_i) begin
      // Decode holds its instruction; a bubble enters reg.
      state_d        = ST_DEP;
      decode_valid_d = decode_valid_q;
      reg_valid_d    = 1'b0;
      alu_valid_d    = reg_valid_q;
      wb_valid_d     = alu_valid_q;
    end else if (branch_conflict_i) begin
      // Fetch is frozen, so decode receives a bubble while the rest drains.
      state_d        = ST_BR;
      decode_valid_d = 1'b0;
      reg_valid_d    = decode_valid_q;
      alu_valid_d    = reg_valid_q;
      wb_valid_d     = alu_valid_q;
    end else begin
      state_d        = ST_RUN;
      decode_valid_d = fetch_valid_i;
      reg_valid_d    = decode_valid_q;
      alu_valid_d    = reg_valid_q;
      wb_valid_d     = alu_valid_q;
    end
  end

  // Stall bookkeeping: saturating total, per-run length and sticky timeout.
  always_comb begin
    stall_s = (state_d != ST_RUN);
    if (stall_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (!stall_s) begin
      run_len_d = 8'd0;
    end else if (run_len_q != 8'hFF) begin
      run_len_d = run_len_q + 8'd1;
    end else begin
      run_len_d = run_len_q;
    end
    if (stall_s && (run_len_d >= MAX_STALL_L)) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // State registers; reset aborts any stall without waiting for a clock.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q        <= ST_RUN;
      decode_valid_q <= 1'b0;
      reg_valid_q    <= 1'b0;
      alu_valid_q    <= 1'b0;
      wb_valid_q     <= 1'b0;
      stall_cnt_q    <= {STALL_CNT_W{1'b0}};
      run_len_q      <= 8'd0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      decode_valid_q <= decode_valid_d;
      reg_valid_q    <= reg_valid_d;
      alu_valid_q    <= alu_valid_d;
      wb_valid_q     <= wb_valid_d;
      stall_cnt_q    <= stall_cnt_d;
      run_len_q      <= run_len_d;
      timeout_q      <= timeout_d;
    end
  end

  assign state_o         = state_q;
  assign decode_valid_o  = decode_valid_q;
  assign reg_valid_o     = reg_valid_q;
  assign alu_valid_o     = alu_valid_q;
  assign wb_valid_o      = wb_valid_q;
  assign stall_cnt_o     = stall_cnt_q;
  assign stall_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a directed driver pushes hand-computed expectations
// into a queue; a monitor pops one entry after every rising edge and
// compares. A second instance with a 4-bit stall counter shares the inputs.
module tb_pipe_ctrl;

  logic        clk;
  logic        arstn;
  logic        reg_conflict_i;
  logic        branch_conflict_i;
  logic        fetch_valid_i;
  logic        flush_i;
  logic        pc_en_o, decode_en_o;
  logic        decode_valid_o, reg_valid_o, alu_valid_o, wb_valid_o;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt_o;
  logic        stall_timeout_o;
  // narrow-counter instance
  logic        pc_en4, decode_en4;
  logic        dv4, rv4, av4, wv4;
  logic [1:0]  state4;
  logic [3:0]  stall_cnt4;
  logic        timeout4;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int         id;
    logic       pc;
    logic       de;
    logic [3:0] v;      // {decode, reg, alu, wb}
    logic [1:0] st;
    int         cnt;
    int         cnt4;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];
  int   vec_id = 0;

  pipe_ctrl #(.STALL_CNT_W(16), .MAX_STALL(8)) dut (
    .clk(clk), .arstn(arstn),
    .reg_conflict_i(reg_conflict_i), .branch_conflict_i(branch_conflict_i),
    .fetch_valid_i(fetch_valid_i), .flush_i(flush_i),
    .pc_en_o(pc_en_o), .decode_en_o(decode_en_o),
    .decode_valid_o(decode_valid_o), .reg_valid_o(reg_valid_o),
    .alu_valid_o(alu_valid_o), .wb_valid_o(wb_valid_o),
    .state_o(state_o), .stall_cnt_o(stall_cnt_o),
    .stall_timeout_o(stall_timeout_o)
  );

  pipe_ctrl #(.STALL_CNT_W(4), .MAX_STALL(8)) dut4 (
    .clk(clk), .arstn(arstn),
    .reg_conflict_i(reg_conflict_i), .branch_conflict_i(branch_conflict_i),
    .fetch_valid_i(fetch_valid_i), .flush_i(flush_i),
    .pc_en_o(pc_en4), .decode_en_o(decode_en4),
    .decode_valid_o(dv4), .reg_valid_o(rv4),
    .alu_valid_o(av4), .wb_valid_o(wv4),
    .state_o(state4), .stall_cnt_o(stall_cnt4),
    .stall_timeout_o(timeout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input int act, input int expv);
    tests_run++;
    if (act != expv) begin
      tests_failed++;
      $display("FAIL %s vec%0d: got %0d expected %0d", nm, id, act, expv);
    end
  endtask

  // Apply one input vector at the falling edge and queue what should be
  // visible just after the following rising edge.
  task automatic apply(input logic fv, input logic rc, input logic bc, input logic fl,
                       input logic pc, input logic de, input logic [3:0] v,
                       input logic [1:0] st, input int cnt, input int cnt4,
                       input logic tmo);
    exp_t e;
    @(negedge clk);
    fetch_valid_i     = fv;
    reg_conflict_i    = rc;
    branch_conflict_i = bc;
    flush_i           = fl;
    e.id = vec_id; e.pc = pc; e.de = de; e.v = v; e.st = st;
    e.cnt = cnt; e.cnt4 = cnt4; e.tmo = tmo;
    exp_q.push_back(e);
    vec_id++;
  endtask

  // Monitor: inputs are stable until the next falling edge, so the
  // combinational enables and the freshly updated registers are both
  // valid 1 time unit after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc_en",        e.id, int'(pc_en_o),         int'(e.pc));
        chk("decode_en",    e.id, int'(decode_en_o),     int'(e.de));
        chk("valids",       e.id, int'({decode_valid_o, reg_valid_o, alu_valid_o, wb_valid_o}), int'(e.v));
        chk("state",        e.id, int'(state_o),         int'(e.st));
        chk("stall_cnt",    e.id, int'(stall_cnt_o),     e.cnt);
        chk("stall_cnt_w4", e.id, int'(stall_cnt4),      e.cnt4);
        chk("timeout",      e.id, int'(stall_timeout_o), int'(e.tmo));
      end
    end
  end

  task automatic drain();
    int budget;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    chk("drain_timeout", vec_id, exp_q.size(), 0);
  endtask

  initial begin
    arstn = 1'b0;
    fetch_valid_i = 1'b0; reg_conflict_i = 1'b0;
    branch_conflict_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    arstn = 1'b1;

    //     fv    rc    bc    fl    pc    de    valids   st    cnt cnt4 tmo
    // reset state
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 2'd0, 0,  0,  1'b0);
    // fill: wb valid four cycles after first fetch
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 2'd0, 0,  0,  1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1100, 2'd0, 0,  0,  1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1110, 2'd0, 0,  0,  1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 2'd0, 0,  0,  1'b0);
    // dependence for 2 cycles: decode holds, two bubbles into reg
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 2'd1, 1,  1,  1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 2'd1, 2,  2,  1'b0);
    // conflict drops: held instruction moves into reg
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1100, 2'd0, 2,  2,  1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1110, 2'd0, 2,  2,  1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 2'd0, 2,  2,  1'b0);
    // branch for 3 cycles: decode bubbles, pipe drains
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0111, 2'd2, 3,  3,  1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0011, 2'd2, 4,  4,  1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 2'd2, 5,  5,  1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 2'd0, 5,  5,  1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1100, 2'd0, 5,  5,  1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1110, 2'd0, 5,  5,  1'b0);
    // both conflicts: dependence wins
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 2'd1, 6,  6,  1'b0);
    // flush with both conflicts high overrides everything
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd0, 6,  6,  1'b0);
    // dependence for MAX_STALL=8 cycles: timeout after the 8th only
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 7 + i, 7 + i, (i == 7) ? 1'b1 : 1'b0);
    end
    // timeout is sticky across run and flush
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 2'd0, 14, 14, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd0, 14, 14, 1'b1);
    // 20 branch stalls: 16-bit counter keeps counting, 4-bit one pins at 15
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd2, 15 + i, 15, 1'b1);
    end
    drain();

    // Reset pulse mid-stall, between clock edges.
    @(negedge clk);
    #2;
    arstn = 1'b0;
    #1;
    chk("arst_valids",    vec_id, int'({decode_valid_o, reg_valid_o, alu_valid_o, wb_valid_o}), 0);
    chk("arst_state",     vec_id, int'(state_o),         0);
    chk("arst_cnt",       vec_id, int'(stall_cnt_o),     0);
    chk("arst_cnt_w4",    vec_id, int'(stall_cnt4),      0);
    chk("arst_timeout",   vec_id, int'(stall_timeout_o), 0);
    chk("arst_timeout_w4",vec_id, int'(timeout4),        0);
    @(negedge clk);
    branch_conflict_i = 1'b0;
    fetch_valid_i     = 1'b0;
    arstn             = 1'b1;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 2'd0, 0,  0,  1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage core (fetch, decode, reg, alu, wb). It consumes the register-dependence and branch conflict flags produced by the hazard detector and turns them into per-stage enable and valid bits. It holds fetch and decode on a dependence, inserts bubbles, freezes fetch while a branch is in flight, and applies external flushes. It also keeps a registered stall state, a saturating stall counter and a sticky stall-timeout flag for debug.

## Interface
- STALL_CNT_W, 16, width of the saturating stall-cycle counter
- MAX_STALL, 8, consecutive stalled cycles that set the timeout flag (must be ≥1 and < 2^8)
- clk  input  1  core clock, all state updates on rising edge
- arstn  input  1  reset, asynchronous and active-low
- reg_conflict_i  input  1  decode instruction depends on the reg-stage destination
- branch_conflict_i  input  1  branch present in reg, alu or wb stage
- fetch_valid_i  input  1  fetch stage presents an instruction this cycle
- flush_i  input  1  external flush (redirect or exception), kills all in-flight instructions
- pc_en_o  output  1  PC/fetch register may advance (combinational)
- decode_en_o  output  1  decode pipeline register may load (combinational)
- decode_valid_o, reg_valid_o, alu_valid_o, wb_valid_o  output  1 each  registered stage-valid bits
- state_o  output  2  registered stall state: 0 RUN, 1 DEP, 2 BR
- stall_cnt_o  output  STALL_CNT_W  total stalled cycles since reset, saturating
- stall_timeout_o  output  1  sticky: a stall run reached MAX_STALL

## Operation
- The priority of the current-cycle decision is flush_i, then reg_conflict_i, then branch_conflict_i, then run.
- Combinational enables:
  - pc_en_o = !reg_conflict_i && !branch_conflict_i && !flush_i
  - decode_en_o = !reg_conflict_i || flush_i
- Valid bits update on each clock as follows:
  - flush_i: all four valid bits are set to 0.
  - reg_conflict_i: decode_valid holds. reg_valid is set to 0 (bubble). alu_valid takes reg_valid. wb_valid takes alu_valid.
  - branch_conflict_i only: decode_valid is set to 0 (bubble into decode). The other stages shift normally (reg takes decode, alu takes reg, wb takes alu).
  - run: decode_valid takes fetch_valid_i, and all later stages shift normally.
- state_o next value:
  - DEP if reg_conflict_i and not flush_i.
  - Otherwise BR if branch_conflict_i and not flush_i.
  - Otherwise RUN. A flush forces RUN.
- The stall counter increments by 1 on every cycle whose next state is DEP or BR. It saturates at 2^STALL_CNT_W−1.
- Run-length counter (internal, 8 bits):
  - It increments on each stalled cycle and clears on any RUN cycle.
  - When it reaches MAX_STALL, stall_timeout_o is set. It stays set until reset; flush does not clear it.
- When reg_conflict_i and branch_conflict_i are asserted together, the dependence behaviour applies and state is DEP. Fetch is frozen in either case.

## Timing
- Reset (arstn low, asynchronous) drives:
  - all valid bits to 0
  - state_o to RUN
  - stall_cnt_o to 0
  - the run-length counter to 0
  - stall_timeout_o to 0
- Combinational outputs have no reset value beyond their input-derived value.
- pc_en_o and decode_en_o have zero-cycle latency from the conflict and flush inputs.
- Valid bits and state_o reflect a decision one cycle after the inputs that caused it.
- An instruction accepted with fetch_valid_i in cycle N shows decode_valid_o=1 from N+1. With no stalls it reaches wb_valid_o at N+4.
- A reg_conflict_i held for k cycles inserts exactly k bubbles into reg. The decode instruction moves to reg on the first cycle the conflict is low.
- flush_i in the same cycle as any conflict overrides it: pc_en_o=0, decode_en_o=1, and all valids are 0 on the next cycle.
- Asserting arstn mid-stall aborts the stall immediately. It does not wait for a clock edge.
- stall_cnt_o at saturation holds its value and never wraps.

## Test plan
- Reset, then fetch_valid_i=1 for 4 cycles with no conflicts -> pc_en_o=1 throughout, and valids fill in order so that wb_valid_o=1 at cycle 4 after the first fetch. state_o=0 and stall_cnt_o=0.
- With a full pipe, reg_conflict_i=1 for 2 cycles -> pc_en_o=0 and decode_en_o=0 for those cycles. reg_valid_o=0 for 2 cycles, decode_valid_o stays 1, state_o=1, stall_cnt_o=2.
- branch_conflict_i=1 for 3 cycles -> pc_en_o=0 and decode_valid_o=0 for 3 cycles. The bubble shifts through reg, alu and wb. state_o=2, stall_cnt_o=3.
- reg_conflict_i=1 and branch_conflict_i=1 together for 1 cycle -> DEP behaviour (decode holds, reg bubble) and state_o=1. Then assert flush_i with both conflicts high -> all valids 0 on the next cycle and state_o=0.
- Hold reg_conflict_i for MAX_STALL=8 cycles -> stall_timeout_o rises after the 8th stalled cycle. It stays 1 after the conflict drops and after a flush, and clears only on arstn.
- With STALL_CNT_W=4, stall for 20 cycles -> stall_cnt_o reaches 15 and holds there. Pulsing arstn low mid-stall zeroes all registered outputs asynchronously.
